// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory sequencer.
// Sizes follow the ReqSize field; the helpers keep decode logic out of the controller body.
package mem_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 10;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // Index of the most significant byte of a request (N-1).
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_index = 2'd0;
      SIZE_HALF: last_index = 2'd1;
      default:   last_index = 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] acc, input logic [1:0] size,
                                              input logic sgn);
    case (size)
      SIZE_BYTE: extend_load = {{24{sgn & acc[7]}}, acc[7:0]};
      SIZE_HALF: extend_load = {{16{sgn & acc[15]}}, acc[15:0]};
      default:   extend_load = acc;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl.sv
// Sequences one load/store request into big-endian byte accesses on a 1024x8 memory
// whose array acts on the rising edge of its enable; each byte takes SETUP then ACCESS.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRData,
  output logic              AlignErr,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemDataIn,
  input  logic [7:0]        MemDataOut
);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, off_reg, size_reg;
  logic              write_reg, signed_reg, err_reg;
  logic [ADDR_W-1:0] addr_reg, mem_address_reg;
  logic [DATA_W-1:0] wdata_reg, acc_reg;
  logic              mem_rw_reg;
  logic [7:0]        mem_din_reg;

  logic              req_bad;
  logic [1:0]        first_cnt, cnt_dec, off_inc;

  assign req_bad   = (ReqSize == SIZE_ILLEGAL) || misaligned(ReqSize, ReqAddr[1:0]);
  assign first_cnt = last_index(ReqSize);
  assign cnt_dec   = cnt_reg - 2'd1;
  assign off_inc   = off_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (ReqValid) state_next = req_bad ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: state_next = (cnt_reg == 2'd0) ? ST_DONE : ST_SETUP;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory lines are only reloaded on the edges that enter SETUP, so they are
  // settled before MemEnable rises and held for the whole ACCESS cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 2'd0;
      off_reg         <= 2'd0;
      size_reg        <= SIZE_BYTE;
      write_reg       <= 1'b0;
      signed_reg      <= 1'b0;
      err_reg         <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      acc_reg         <= '0;
      mem_address_reg <= '0;
      mem_rw_reg      <= 1'b0;
      mem_din_reg     <= 8'h00;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (ReqValid) begin
            write_reg  <= ReqWrite;
            size_reg   <= ReqSize;
            signed_reg <= ReqSigned;
            addr_reg   <= ReqAddr;
            wdata_reg  <= ReqWData;
            err_reg    <= req_bad;
            acc_reg    <= '0;
            cnt_reg    <= first_cnt;
            off_reg    <= 2'd0;
            if (!req_bad) begin
              mem_address_reg <= ReqAddr;
              mem_rw_reg      <= ReqWrite;
              mem_din_reg     <= ReqWrite ? ReqWData[{first_cnt, 3'b000} +: 8] : 8'h00;
            end
          end
        end
        ST_ACCESS: begin
          if (!write_reg) acc_reg <= {acc_reg[DATA_W-9:0], MemDataOut};
          if (cnt_reg != 2'd0) begin
            cnt_reg         <= cnt_dec;
            off_reg         <= off_inc;
            mem_address_reg <= addr_reg + ADDR_W'(off_inc);
            mem_din_reg     <= write_reg ? wdata_reg[{cnt_dec, 3'b000} +: 8] : 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReqReady     = (state_reg == ST_IDLE);
  assign MemEnable    = (state_reg == ST_ACCESS);
  assign RspValid     = (state_reg == ST_DONE);
  assign AlignErr     = RspValid & err_reg;
  assign RspRData     = (RspValid && !err_reg && !write_reg)
                        ? extend_load(acc_reg, size_reg, signed_reg) : '0;
  assign MemReadWrite = mem_rw_reg;
  assign MemAddress   = mem_address_reg;
  assign MemDataIn    = mem_din_reg;

endmodule
